h_u_rca8_mp_seq: RTL
====================

Name: h_u_rca8_mp_seq

Overview:
- Multi-precision unsigned adder sequencer.
- Adds two LIMBS×8-bit operands using one shared 8-bit ripple-carry slice (chain of fa cells with carry-in), one limb per clock, least-significant limb first.
- Sits between an operand producer and a result consumer, with valid/ready on both sides.
- Lets wide additions reuse the 8-bit RCA datapath instead of instantiating a LIMBS×8 chain.

Parameters:
- LIMBS, 4, number of 8-bit limbs per operand (legal 2..16).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  8*LIMBS  operand A, unsigned
- b  input  8*LIMBS  operand B, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  8*LIMBS+1  sum; MSB is final carry
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=0 while in reset, out_valid=0, out=0, busy=0, carry register=0, limb counter=0.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b into shift registers, clear carry, counter=0, go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle the slice computes a_limb[i] + b_limb[i] + carry.
  - The 8-bit sum is written to out[8i+7:8i] and the slice carry-out goes to the carry register; counter increments.
  - When counter==LIMBS-1, write out[8*LIMBS] = carry-out and go to DONE in the same edge.
- State DONE:
  - out_valid=1; out held stable.
  - On out_ready: out_valid drops next cycle and the block returns to IDLE.
  - out retains its value until the next transaction overwrites limbs.
- Latency: handshake accepted at edge T; out_valid high after edge T+LIMBS. Throughput is one transaction per LIMBS+2 cycles with out_ready tied high.
- Handshake rules:
  - in_valid asserted during RUN/DONE is ignored; the producer must hold it until in_ready.
  - out_valid never drops without out_ready.
  - The a/b inputs are sampled only at the accept edge; later changes have no effect.
- Arithmetic: result is exact unsigned; max 2×(2^(8·LIMBS)−1) fits in 8·LIMBS+1 bits. The carry ripples across limbs via the register only, never combinationally across cycles.
- Reset mid-operation: the transaction is aborted with no partial out_valid. After release the block is in IDLE and accepts on the first cycle.
- Limb counter width is clog2(LIMBS); no wrap beyond LIMBS-1.

Optional Feature:
- Macro: H_U_RCA_MP_SEQ_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow of the LIMBS×8 addition.
  - ovf = carry-in XOR carry-out of bit 7 of the most-significant limb.
  - Valid with out_valid, reset 0, held stable in DONE.
- Undefined: port absent, no extra logic.

Test Plan (LIMBS=4):
- Accept a=0xFFFFFFFF, b=0x00000001 at edge T -> out_valid high after T+4, out=0x1_00000000. With H_U_RCA_MP_SEQ_OVF_EN, ovf=0.
- a=0x00FF00FF, b=0x00010001 -> out=0x0_01000100, exercising inter-limb carry through the register.
- a=0x7FFFFFFF, b=0x00000001 with H_U_RCA_MP_SEQ_OVF_EN -> out=0x0_80000000, ovf=1.
- Back-pressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out stable throughout, in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
- Pull rst_n low in the 2nd RUN cycle of a=0x12345678, b=0x11111111 -> out_valid=0, out=0, busy=0 immediately. After release, accept a=2, b=3 -> out=0x0_00000005.
- in_valid held high continuously with out_ready=1 and operands 1+1, 2+2 -> results 2 then 4. Accepts are spaced 6 cycles apart, and no operand is consumed during RUN/DONE.

Source files
------------

// File: rtl/h_u_rca8_mp_seq.sv
// Multi-precision unsigned adder: LIMBS x 8-bit operands summed one limb per clock
// through a shared 8-bit ripple-carry slice. Optional ovf port: H_U_RCA_MP_SEQ_OVF_EN.

module h_u_rca8_mp_seq_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module h_u_rca8_mp_seq #(
  parameter int LIMBS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LIMBS-1:0] a,
  input  logic [8*LIMBS-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LIMBS:0]   out,
  output logic               busy
`ifdef H_U_RCA_MP_SEQ_OVF_EN
  ,
  output logic               ovf
`endif
);
  localparam int W  = 8*LIMBS;
  localparam int CW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_sh, b_sh;
  logic           carry_q;
  logic [CW-1:0]  cnt;
  logic [W:0]     out_q;
  logic [8:0]     c;
  logic [7:0]     s;
  logic           accept, last;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CW'(LIMBS-1));

  // Shared slice: low limb of the shift registers plus the registered carry.
  assign c[0] = carry_q;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    h_u_rca8_mp_seq_fa u_fa (
      .a   (a_sh[i]),
      .b   (b_sh[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it stays low while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready = rst_n;
      RUN:     busy = 1'b1;
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      out_q   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_sh    <= a;
          b_sh    <= b;
          carry_q <= 1'b0;
          cnt     <= '0;
        end
        RUN: begin
          out_q[8*cnt +: 8] <= s;
          a_sh    <= a_sh >> 8;
          b_sh    <= b_sh >> 8;
          carry_q <= c[8];
          if (last) out_q[W] <= c[8];
          else      cnt      <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out = out_q;

`ifdef H_U_RCA_MP_SEQ_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ovf_q <= 1'b0;
    else if (state == RUN && last) ovf_q <= c[7] ^ c[8];
  end
  assign ovf = ovf_q;
`endif

endmodule
